relu_sink: RTL and testbench
============================

// Module: relu_sink
// PURPOSE
//  Receiving end of the ReLU output stream: captures output_data samples qualified by the
//  same out_en-style strobe the counter drives, buffers them in a small FIFO and presents
//  them downstream on a valid/ready handshake. Sits after ReLU; flags samples that violate
//  the ReLU contract (bit 7 set) and, optionally, keeps running statistics.
// PARAMETERS
//  DEPTH      4    FIFO entries; power of 2, >= 2
//  DATA_W     8    sample width; matches ReLU output_data
//  CNT_W      16   width of zero_cnt statistic
//  SUM_W      20   width of sum statistic
// PORTS
//  clk         in   1               system clock, rising edge
//  rst_n       in   1               asynchronous active-low reset
//  in_valid    in   1               sample strobe; one sample per high cycle
//  in_data     in   DATA_W          sample from ReLU output_data
//  out_valid   out  1               FIFO head valid
//  out_ready   in   1               downstream accepts head this cycle
//  out_data    out  DATA_W          FIFO head sample
//  fifo_count  out  $clog2(DEPTH)+1 occupied entries, 0..DEPTH
//  overflow    out  1               sticky: sample dropped because FIFO full
//  sign_err    out  1               sticky: accepted sample had MSB set
//  zero_cnt    out  CNT_W           accepted samples equal to 0 (stats build)
//  sum         out  SUM_W           sum of accepted samples (stats build)
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert by system): pointers, fifo_count,
//    out_valid, overflow, sign_err, zero_cnt, sum all 0; out_data 0 while empty.
//  - Write: in_valid && (!full || pop) at rising edge -> in_data stored at wr_ptr, wr_ptr++.
//  - Pop: out_valid && out_ready at rising edge -> rd_ptr++.
//  - Show-ahead: out_data = mem[rd_ptr]; out_valid = (fifo_count != 0), registered count.
//    Latency: sample written at edge N appears on out_valid/out_data after edge N.
//  - Full + in_valid + pop same edge: write accepted, count unchanged, no overflow.
//  - Full + in_valid, no pop: sample dropped, overflow <= 1 (sticky until reset).
//  - Empty: out_ready ignored; no write-through bypass (empty + in_valid -> visible next cycle).
//  - Simultaneous push/pop when non-empty, non-full: count unchanged.
//  - Pointers wrap modulo DEPTH; full = count==DEPTH, empty = count==0.
//  - sign_err <= 1 on any accepted sample with in_data[DATA_W-1]==1; sample still stored.
//  - out_data stable while out_valid && !out_ready (AXI-style hold).
//  - Reset mid-stream: FIFO contents discarded, all flags and stats cleared.
// CONFIGURATION
//  RELU_SINK_STATS_EN defined: on each accepted sample, zero_cnt += (in_data==0) and
//    sum += in_data; both saturate at all-ones, never wrap. Dropped samples not counted.
//  RELU_SINK_STATS_EN undefined: zero_cnt and sum ports present, driven constant 0;
//    no stat registers synthesized.
// TESTING (DEPTH=4, counter THRESHOLD=6 driving in_valid)
//  1 Reset: rst_n=0 with in_valid toggling -> all outputs 0; release -> first strobe with
//    in_data=8'h2E gives out_valid=1, out_data=8'h2E, fifo_count=1 one edge later.
//  2 Fill: out_ready=0, 5 strobes 8'h01..8'h05 -> fifo_count=4, overflow=1 after 5th,
//    then out_ready=1 drains 01,02,03,04 in order; 05 never appears.
//  3 Push+pop at full: count=4, in_valid=1 with out_ready=1 -> count stays 4, overflow=0,
//    head advances by one.
//  4 Sign check: in_data=8'h9A accepted -> sign_err=1, 8'h9A output; stays 1 after drain.
//  5 Backpressure hold: out_ready toggles 0/1 each cycle across 8 samples -> out_data
//    constant while stalled, no loss, no duplication (scoreboard).
//  6 Stats (macro on): 3 samples 00,00,FF -> zero_cnt=2, sum=255; force 4200 samples
//    of FF -> sum saturates at 20'hFFFFF. Macro off: zero_cnt=sum=0 throughout.

Source files
------------

// File: rtl/relu_sink.sv
// Receiving end of the ReLU output stream: small show-ahead FIFO with valid/ready output,
// sticky overflow / sign-error flags and optional saturating statistics (RELU_SINK_STATS_EN).
module relu_sink #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SUM_W  = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      overflow,
  output logic                      sign_err,
  output logic [CNT_W-1:0]          zero_cnt,
  output logic [SUM_W-1:0]          sum
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              overflow_q, overflow_d;
  logic              sign_err_q, sign_err_d;

  logic full;
  logic pop;
  logic wr_en;

  // Head is re-registered from next-state values so out_data is a flop yet still show-ahead.
  always_comb begin
    full        = (count_q == OCC_W'(DEPTH));
    pop         = out_valid_q && out_ready;
    wr_en       = in_valid && (!full || pop);
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + OCC_W'(wr_en) - OCC_W'(pop);
    overflow_d  = overflow_q || (in_valid && !wr_en);
    sign_err_d  = sign_err_q || (wr_en && in_data[DATA_W-1]);
    out_data_d  = '0;
    if (wr_en) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    out_valid_d = (count_d != '0);
    if (out_valid_d) begin
      out_data_d = mem_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      sign_err_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      sign_err_q  <= sign_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign sign_err   = sign_err_q;

`ifdef RELU_SINK_STATS_EN
  logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W:0]   sum_ext;

  // Saturating statistics over accepted samples only.
  always_comb begin
    zero_cnt_d = zero_cnt_q;
    sum_d      = sum_q;
    sum_ext    = {1'b0, sum_q} + (SUM_W+1)'(in_data);
    if (wr_en) begin
      if ((in_data == '0) && (zero_cnt_q != {CNT_W{1'b1}})) begin
        zero_cnt_d = zero_cnt_q + CNT_W'(1);
      end
      sum_d = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt_q <= '0;
      sum_q      <= '0;
    end else begin
      zero_cnt_q <= zero_cnt_d;
      sum_q      <= sum_d;
    end
  end

  assign zero_cnt = zero_cnt_q;
  assign sum      = sum_q;
`else
  assign zero_cnt = '0;
  assign sum      = '0;
`endif

endmodule

// File: tb/tb_relu_sink.sv
// Self-checking bench for relu_sink: randomized stimulus against a queue-based reference
// model; expected statistics follow RELU_SINK_STATS_EN.
module tb_relu_sink;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SUM_W  = 20;
`ifdef RELU_SINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam longint SUM_MAX = (64'd1 << SUM_W) - 1;
  localparam longint ZC_MAX  = (64'd1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        fifo_count;
  logic              overflow;
  logic              sign_err;
  logic [CNT_W-1:0]  zero_cnt;
  logic [SUM_W-1:0]  sum;

  relu_sink #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_count(fifo_count), .overflow(overflow), .sign_err(sign_err),
    .zero_cnt(zero_cnt), .sum(sum)
  );

  always #5 clk = ~clk;

  int vec  = 0;
  int errs = 0;

  // Reference model: an ordered queue plus sticky flags and saturating stats.
  logic [DATA_W-1:0] mq[$];
  bit     m_ovf, m_sign;
  longint m_zero, m_sum;

  function automatic void model_clear();
    mq.delete();
    m_ovf = 0; m_sign = 0; m_zero = 0; m_sum = 0;
  endfunction

  function automatic logic [DATA_W-1:0] exp_data();
    return (mq.size() != 0) ? mq[0] : '0;
  endfunction

  function automatic logic [CNT_W-1:0] exp_zero();
    return STATS ? CNT_W'(m_zero) : '0;
  endfunction

  function automatic logic [SUM_W-1:0] exp_sum();
    return STATS ? SUM_W'(m_sum) : '0;
  endfunction

  // Drive one cycle and advance the model by the same transaction rules.
  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit r);
    bit popped, pushed;
    logic [DATA_W-1:0] junk;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = r;
    @(posedge clk);
    popped = (mq.size() != 0) && r;
    pushed = v && ((mq.size() < DEPTH) || popped);
    if (popped) junk = mq.pop_front();
    if (v && !pushed) m_ovf = 1;
    if (pushed) begin
      mq.push_back(d);
      if (d[DATA_W-1]) m_sign = 1;
      if (d == 0 && m_zero < ZC_MAX) m_zero++;
      m_sum = (m_sum + d > SUM_MAX) ? SUM_MAX : m_sum + d;
    end
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; in_data = 8'($urandom);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    model_clear();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && out_valid; i++) cycle(1'b0, '0, 1'b1);
    vec++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL drain_timeout out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset();
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec++;
    if ({out_valid, out_data, fifo_count, overflow, sign_err, zero_cnt, sum} !== '0) begin
      errs++;
      $display("FAIL reset_async v=%b d=%h cnt=%0d ovf=%b se=%b zc=%0d sum=%0d want all 0",
               out_valid, out_data, fifo_count, overflow, sign_err, zero_cnt, sum);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; in_data = 8'($urandom);
    end
    #1;
    vec++;
    if ({out_valid, out_data, fifo_count, overflow, sign_err, zero_cnt, sum} !== '0) begin
      errs++; $display("FAIL reset_held v=%b cnt=%0d want 0", out_valid, fifo_count);
    end
    in_valid = 1'b0;
    model_clear();
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b1);
    vec++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL reset_release_idle out_valid=%b want 0", out_valid);
    end
    cycle(1'b1, 8'h2E, 1'b0);
    vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h2E || fifo_count !== 3'd1) begin
      errs++;
      $display("FAIL first_strobe v=%b d=%h cnt=%0d want 1 2e 1", out_valid, out_data, fifo_count);
    end
  endtask

  task automatic test_fill();
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      vec++;
      if (overflow !== (i == 5)) begin
        errs++; $display("FAIL fill_ovf step=%0d ovf=%b want %b", i, overflow, i == 5);
      end
    end
    vec++;
    if (fifo_count !== 3'd4) begin
      errs++; $display("FAIL fill_count cnt=%0d want 4", fifo_count);
    end
    for (int i = 1; i <= 4; i++) begin
      vec++;
      if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
        errs++; $display("FAIL fill_drain idx=%0d v=%b d=%h want 1 %h", i, out_valid, out_data, 8'(i));
      end
      cycle(1'b0, '0, 1'b1);
    end
    vec++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 || out_data !== 8'h00 || overflow !== 1'b1) begin
      errs++;
      $display("FAIL fill_empty v=%b cnt=%0d d=%h ovf=%b want 0 0 00 1",
               out_valid, fifo_count, out_data, overflow);
    end
  endtask

  task automatic test_push_pop_full();
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0);
    cycle(1'b1, 8'hA4, 1'b1);
    vec++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0 || out_data !== 8'hA1) begin
      errs++;
      $display("FAIL push_pop_full cnt=%0d ovf=%b d=%h want 4 0 a1", fifo_count, overflow, out_data);
    end
    cycle(1'b1, 8'h33, 1'b1);
    vec++;
    if (fifo_count !== 3'd4 || out_data !== 8'hA2) begin
      errs++; $display("FAIL push_pop_full2 cnt=%0d d=%h want 4 a2", fifo_count, out_data);
    end
    drain();
  endtask

  task automatic test_sign();
    apply_reset();
    cycle(1'b1, 8'h9A, 1'b0);
    vec++;
    if (sign_err !== 1'b1 || out_data !== 8'h9A) begin
      errs++; $display("FAIL sign_set se=%b d=%h want 1 9a", sign_err, out_data);
    end
    drain();
    vec++;
    if (sign_err !== 1'b1) begin
      errs++; $display("FAIL sign_sticky se=%b want 1", sign_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] sent[$];
    logic [DATA_W-1:0] got[$];
    logic [DATA_W-1:0] prev_d;
    bit prev_stall, r, v;
    int n = 0;
    apply_reset();
    prev_stall = 0; prev_d = '0;
    for (int c = 0; c < 60 && (n < 8 || out_valid); c++) begin
      r = c[0];
      v = (n < 8) && ((mq.size() < DEPTH) || (r && mq.size() != 0));
      if (prev_stall) begin
        vec++;
        if (out_data !== prev_d) begin
          errs++; $display("FAIL hold cyc=%0d d=%h want %h", c, out_data, prev_d);
        end
      end
      if (out_valid && r) got.push_back(out_data);
      prev_stall = out_valid && !r;
      prev_d     = out_data;
      if (v) begin
        sent.push_back(8'($urandom));
        cycle(1'b1, sent[n], r);
        n++;
      end else begin
        cycle(1'b0, '0, r);
      end
    end
    vec++;
    if (got.size() != 8 || got != sent || overflow !== 1'b0) begin
      errs++; $display("FAIL scoreboard got=%0d items want 8, order_ok=%b ovf=%b",
                       got.size(), got == sent, overflow);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      cycle(1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
      vec++;
      if (out_valid !== (mq.size() != 0) || out_data !== exp_data() ||
          fifo_count !== 3'(mq.size()) || overflow !== m_ovf || sign_err !== m_sign ||
          zero_cnt !== exp_zero() || sum !== exp_sum()) begin
        errs++;
        $display("FAIL random cyc=%0d v=%b d=%h cnt=%0d ovf=%b se=%b zc=%0d sum=%0d want %b %h %0d %b %b %0d %0d",
                 c, out_valid, out_data, fifo_count, overflow, sign_err, zero_cnt, sum,
                 mq.size() != 0, exp_data(), mq.size(), m_ovf, m_sign, exp_zero(), exp_sum());
      end
    end
  endtask

  task automatic test_stats();
    apply_reset();
    cycle(1'b1, 8'h00, 1'b1);
    cycle(1'b1, 8'h00, 1'b1);
    cycle(1'b1, 8'hFF, 1'b1);
    vec++;
    if (zero_cnt !== (STATS ? 16'd2 : 16'd0) || sum !== (STATS ? 20'd255 : 20'd0)) begin
      errs++; $display("FAIL stats_small zc=%0d sum=%0d want %0d %0d",
                       zero_cnt, sum, STATS ? 2 : 0, STATS ? 255 : 0);
    end
    for (int i = 0; i < 4200; i++) cycle(1'b1, 8'hFF, 1'b1);
    vec++;
    if (sum !== (STATS ? 20'hFFFFF : 20'h0) || zero_cnt !== (STATS ? 16'd2 : 16'd0)) begin
      errs++; $display("FAIL stats_sat sum=%h zc=%0d want %h %0d",
                       sum, zero_cnt, STATS ? 20'hFFFFF : 20'h0, STATS ? 2 : 0);
    end
    vec++;
    if (sum !== exp_sum()) begin
      errs++; $display("FAIL stats_model sum=%h want %h", sum, exp_sum());
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_fill();
    test_push_pop_full();
    test_sign();
    test_back_to_back();
    test_random();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
